// File: rtl/uart_piso_tx.sv
// uart_piso_tx: 8-bit UART transmitter with a parity bit, oversampled bit timing.
// Frame layout on the line, LSB first: start(0), data[7:0], parity, stop(1).
// Each frame bit is held for OVERSAMPLE baud_clk cycles. done_flag is a one-cycle
// pulse in the IDLE cycle that follows the last stop-bit cycle. A send sampled in
// that cycle starts the next frame on the following edge.
module uart_piso_tx #(
  parameter int unsigned OVERSAMPLE = 16
) (
  input  logic        baud_clk,
  input  logic        reset_n,
  input  logic        send,
  input  logic [7:0]  data_in,
  input  logic        parity_odd,
  output logic        data_tx,
  output logic        active_flag,
  output logic        done_flag,
  output logic [10:0] frame_out
);

  localparam int unsigned OS_W     = (OVERSAMPLE > 1) ? $clog2(OVERSAMPLE) : 1;
  localparam int unsigned BIT_W    = 4;
  localparam int unsigned FRAME_W  = 11;
  localparam logic [OS_W-1:0]  OS_LAST  = OS_W'(OVERSAMPLE - 1);
  localparam logic [BIT_W-1:0] BIT_LAST = BIT_W'(FRAME_W - 1);

  typedef enum logic {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } state_t;

  state_t             state;
  logic [BIT_W-1:0]   bit_cnt;
  logic [OS_W-1:0]    os_cnt;

  logic               parity_c;
  logic [FRAME_W-1:0] frame_c;
  logic [BIT_W-1:0]   next_bit_c;

  // Parity bit: even parity is the XOR of the data, odd parity its complement.
  assign parity_c   = parity_odd ? ~^data_in : ^data_in;
  // Frame assembled from the live inputs; only latched on the accepting edge.
  assign frame_c    = {1'b1, parity_c, data_in, 1'b0};
  // Index of the frame bit that goes on the line at the next bit boundary.
  assign next_bit_c = bit_cnt + BIT_W'(1);

  // Transmit FSM: accepts a request in IDLE and shifts the latched frame out.
  always_ff @(posedge baud_clk or negedge reset_n) begin
    if (!reset_n) begin
      state       <= IDLE;
      bit_cnt     <= '0;
      os_cnt      <= '0;
      data_tx     <= 1'b1;
      active_flag <= 1'b0;
      done_flag   <= 1'b0;
      frame_out   <= '0;
    end else begin
      done_flag <= 1'b0;
      case (state)
        IDLE: begin
          data_tx     <= 1'b1;
          active_flag <= 1'b0;
          if (send) begin
            frame_out   <= frame_c;
            state       <= SHIFT;
            bit_cnt     <= '0;
            os_cnt      <= '0;
            data_tx     <= 1'b0;
            active_flag <= 1'b1;
          end
        end
        SHIFT: begin
          if (os_cnt == OS_LAST) begin
            os_cnt <= '0;
            if (bit_cnt == BIT_LAST) begin
              state       <= IDLE;
              bit_cnt     <= '0;
              data_tx     <= 1'b1;
              active_flag <= 1'b0;
              done_flag   <= 1'b1;
            end else begin
              bit_cnt <= next_bit_c;
              data_tx <= frame_out[next_bit_c];
            end
          end else begin
            os_cnt <= os_cnt + OS_W'(1);
          end
        end
        default: begin
          state       <= IDLE;
          data_tx     <= 1'b1;
          active_flag <= 1'b0;
        end
      endcase
    end
  end

endmodule
